// File: rtl/stopwatch_pkg.sv
// Shared state encoding, key-code constants and BCD helpers for the stopwatch.
// The LAP feature is compiled in only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_START,
    CMD_LAP,
    CMD_CLEAR
  } sw_cmd_e;

  localparam logic [7:0] KEY_START = 8'h29;
  localparam logic [7:0] KEY_LAP   = 8'h4B;
  localparam logic [7:0] KEY_CLEAR = 8'h21;

  // Rollover value per digit, index 0 = cs1 ... index 5 = min10.
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  function automatic sw_cmd_e decode_key(input logic valid, input logic [7:0] code,
                                         input logic lap_en);
    sw_cmd_e cmd;
    cmd = CMD_NONE;
    if (valid) begin
      case (code)
        KEY_START: cmd = CMD_START;
        KEY_LAP:   cmd = lap_en ? CMD_LAP : CMD_NONE;
        KEY_CLEAR: cmd = CMD_CLEAR;
        default:   cmd = CMD_NONE;
      endcase
    end
    return cmd;
  endfunction

  // Ripple a +1 through the six digits; carry out of min10 is dropped so
  // 59:59.99 wraps to 00:00.00.
  function automatic logic [23:0] bcd_time_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (t[i*4 +: 4] == DIGIT_MAX[i]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Time-base divider: counts 0..DIV-1 while en is high, pulses tick on the
// last count and wraps. Holds when en is low; clr forces it back to zero.
module sw_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Keyboard-driven stopwatch: START/LAP/CLEAR FSM, 10 ms time base, mm:ss.cc BCD.
// Define STOPWATCH_LAP_EN to build in the lap-freeze feature.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        run,
  output logic        tick_en,
  output logic [23:0] disp,
  output logic        lap_hold,
  output logic [1:0]  state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif

  sw_cmd_e     w_cmd;
  sw_state_e   r_state;
  logic        r_run;
  logic        w_tick;
  logic        w_clr;
  logic [23:0] r_time;

  assign w_cmd = decode_key(key_valid, key_code, LAP_EN);
  assign w_clr = (r_state == ST_PAUSE) && (w_cmd == CMD_CLEAR);

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_hold;
  logic        w_lap_cap;
  logic [23:0] r_lap;

  assign w_lap_cap = (r_state == ST_RUN) && (w_cmd == CMD_LAP);
`endif

  // run/lap_hold are registered from the same decision as the state, so they
  // track the new state in the cycle after the command edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap_hold <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_cmd == CMD_START) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
        ST_RUN:
          if (w_cmd == CMD_START) begin
            r_state <= ST_PAUSE;
            r_run   <= 1'b0;
          end
`ifdef STOPWATCH_LAP_EN
          else if (w_cmd == CMD_LAP) begin
            r_state    <= ST_LAP;
            r_lap_hold <= 1'b1;
          end
        ST_LAP:
          if (w_cmd == CMD_LAP) begin
            r_state    <= ST_RUN;
            r_lap_hold <= 1'b0;
          end else if (w_cmd == CMD_START) begin
            r_state    <= ST_PAUSE;
            r_run      <= 1'b0;
            r_lap_hold <= 1'b0;
          end
`endif
        ST_PAUSE:
          if (w_cmd == CMD_START) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else if (w_cmd == CMD_CLEAR) begin
            r_state <= ST_IDLE;
          end
        default: begin
          r_state <= ST_IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler sees the pre-edge run, so a tick coinciding with START still counts.
  sw_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_run),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Clear and tick are exclusive: a tick needs run=1, clear only happens in PAUSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time <= '0;
    end else if (w_clr) begin
      r_time <= '0;
    end else if (w_tick) begin
      r_time <= bcd_time_inc(r_time);
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Capture the pre-increment time even if a tick lands on the LAP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap <= '0;
    end else if (w_clr) begin
      r_lap <= '0;
    end else if (w_lap_cap) begin
      r_lap <= r_time;
    end
  end

  assign lap_hold = r_lap_hold;
  assign disp     = r_lap_hold ? r_lap : r_time;
`else
  assign lap_hold = 1'b0;
  assign disp     = r_time;
`endif

  assign run     = r_run;
  assign tick_en = w_tick;
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=1000, TICK_HZ=100 -> DIV=10).
// Reference model keeps time as integer centiseconds; honours STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int T_WRAP  = 360000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam logic [7:0] K_START = 8'h29;
  localparam logic [7:0] K_LAP   = 8'h4B;
  localparam logic [7:0] K_CLR   = 8'h21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        run;
  logic        tick_en;
  logic [23:0] disp;
  logic        lap_hold;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // model: state 0 idle, 1 run, 2 pause, 3 lap; time in centiseconds
  int m_st, m_pre, m_t, m_lap;

  stopwatch_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .run       (run),
    .tick_en   (tick_en),
    .disp      (disp),
    .lap_hold  (lap_hold),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic bit m_run();
    return (m_st == 1) || (m_st == 3);
  endfunction

  function automatic logic [7:0] noise_code();
    logic [7:0] c;
    c = 8'($urandom);
    while (c == K_START || c == K_LAP || c == K_CLR) c = 8'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_t = 0; m_lap = 0;
  endtask

  task automatic model_edge(input bit kv, input logic [7:0] code);
    int cmd, nst, t_old;
    bit run_now, tick;
    run_now = m_run();
    tick    = run_now && (m_pre == DIV - 1);
    cmd     = 0;
    if (kv) begin
      if (code == K_START) cmd = 1;
      else if (code == K_LAP && LAP_EN) cmd = 2;
      else if (code == K_CLR) cmd = 3;
    end
    nst = m_st;
    case (m_st)
      0: if (cmd == 1) nst = 1;
      1: if (cmd == 1) nst = 2; else if (cmd == 2) nst = 3;
      2: if (cmd == 1) nst = 1; else if (cmd == 3) nst = 0;
      3: if (cmd == 2) nst = 1; else if (cmd == 1) nst = 2;
      default: nst = 0;
    endcase
    t_old = m_t;
    if (run_now) m_pre = tick ? 0 : m_pre + 1;
    if (tick) m_t = (m_t + 1) % T_WRAP;
    if (m_st == 1 && nst == 3) m_lap = t_old;
    if (m_st == 2 && nst == 0) begin
      m_pre = 0; m_t = 0; m_lap = 0;
    end
    m_st = nst;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic check_outputs();
    bit er;
    er = m_run();
    chk("run",      32'(run),      32'(er));
    chk("tick_en",  32'(tick_en),  32'(er && (m_pre == DIV - 1)));
    chk("state",    32'(state),    32'(m_st));
    chk("lap_hold", 32'(lap_hold), 32'(m_st == 3));
    chk("disp",     32'(disp),     32'((m_st == 3) ? to_bcd(m_lap) : to_bcd(m_t)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_run"},   32'(run),      32'd0);
    chk({tag, "_tick"},  32'(tick_en),  32'd0);
    chk({tag, "_disp"},  32'(disp),     32'd0);
    chk({tag, "_hold"},  32'(lap_hold), 32'd0);
    chk({tag, "_state"}, 32'(state),    32'd0);
  endtask

  task automatic cyc(input bit kv, input logic [7:0] code);
    key_valid = kv;
    key_code  = code;
    @(posedge clk);
    model_edge(kv, code);
    #1;
    key_valid = 1'b0;
    key_code  = 8'($urandom);
    cyc_n++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom));
  endtask

  initial begin
    int n, dt;
    logic [23:0] d;
    int bnd[8];

    rst_n = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    model_reset();
    #2;
    check_zero("reset");

    // a START strobed during reset must not survive it
    key_valid = 1'b1; key_code = K_START;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_outputs();
    idle(3);

    // BCD increment rule at every carry boundary plus random points
    bnd = '{0, 99, 123, 999, 5999, 35999, 59999, 359999};
    foreach (bnd[i])
      chk("bcd_inc", 32'(stopwatch_pkg::bcd_time_inc(to_bcd(bnd[i]))),
          32'(to_bcd((bnd[i] + 1) % T_WRAP)));
    for (int i = 0; i < 16; i++) begin
      dt = int'($urandom_range(0, T_WRAP - 1));
      chk("bcd_inc_rnd", 32'(stopwatch_pkg::bcd_time_inc(to_bcd(dt))),
          32'(to_bcd((dt + 1) % T_WRAP)));
    end

    // START -> run next cycle, first tick 10 cycles later
    cyc(1'b1, K_START);
    chk("run_after_start", 32'(run), 32'd1);
    n = 1;
    while (!tick_en && n < 20) begin
      idle(1);
      n++;
    end
    chk("first_tick_lat", 32'(n), 32'd10);
    idle(1);
    chk("disp_first_tick", 32'(disp), 32'h000001);

    // one minute of running with random non-command key traffic
    repeat (5999 * DIV) cyc($urandom_range(0, 3) == 0, noise_code());
    chk("disp_1min", 32'(disp), 32'h010000);

    // pause with the prescaler parked at 4, resume -> tick 6 cycles later
    n = 0;
    while (m_pre != 3 && n < 20) begin
      idle(1);
      n++;
    end
    cyc(1'b1, K_START);
    chk("pause_state", 32'(state), 32'd2);
    d = disp;
    idle(50);
    chk("pause_frozen", 32'(disp), 32'(d));
    cyc(1'b1, K_START);
    n = 1;
    while (!tick_en && n < 20) begin
      idle(1);
      n++;
    end
    chk("resume_lat", 32'(n), 32'd6);

    // CLEAR ignored in RUN, honoured in PAUSE
    idle($urandom_range(1, 15));
    cyc(1'b1, K_CLR);
    chk("clr_in_run", 32'(state), 32'd1);
    cyc(1'b1, K_START);
    idle($urandom_range(1, 10));
    cyc(1'b1, K_CLR);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_disp", 32'(disp), 32'h000000);

    // LAP at 01.23: display freezes while live time runs on (ignored without LAP)
    cyc(1'b1, K_START);
    n = 0;
    while (m_t != 123 && n < 2000) begin
      idle(1);
      n++;
    end
    cyc(1'b1, K_LAP);
    idle(30);
    chk("lap_disp", 32'(disp), LAP_EN ? 32'h000123 : 32'(to_bcd(m_t)));
    chk("lap_hold_on", 32'(lap_hold), 32'(LAP_EN));
    chk("lap_state", 32'(state), LAP_EN ? 32'd3 : 32'd1);
    cyc(1'b1, K_LAP);
    chk("lap_release", 32'(disp), 32'(to_bcd(m_t)));
    chk("lap_rel_state", 32'(state), 32'd1);

    // LAP on a tick edge captures the pre-increment time; START leaves LAP
    n = 0;
    while (m_pre != DIV - 1 && n < 20) begin
      idle(1);
      n++;
    end
    d = to_bcd(m_t);
    cyc(1'b1, K_LAP);
    chk("lap_pre_inc", 32'(disp), LAP_EN ? 32'(d) : 32'(to_bcd(m_t)));
    idle(15);
    cyc(1'b1, K_START);
    chk("lap_to_pause", 32'(state), 32'd2);
    chk("lap_to_pause_hold", 32'(lap_hold), 32'd0);
    cyc(1'b1, K_START);

    // START coinciding with a tick: tick counted, then no further ticks
    idle($urandom_range(1, 9));
    n = 0;
    while (m_pre != DIV - 1 && n < 20) begin
      idle(1);
      n++;
    end
    chk("coinc_tick_seen", 32'(tick_en), 32'd1);
    dt = m_t;
    cyc(1'b1, K_START);
    chk("coinc_disp", 32'(disp), 32'(to_bcd((dt + 1) % T_WRAP)));
    chk("coinc_state", 32'(state), 32'd2);
    n = 0;
    repeat (40) begin
      idle(1);
      if (tick_en) n++;
    end
    chk("no_tick_paused", 32'(n), 32'd0);

    // asynchronous reset in the middle of a RUN cycle
    cyc(1'b1, K_START);
    idle($urandom_range(5, 40));
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_outputs();
    cyc(1'b1, K_START);
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
